fp_class_pipe: RTL and testbench

- Multi-lane, pipelined floating-point classifier. Generalises the single-lane, combinational zero-exponent check.
- Per lane, it produces a RISC-V-style 10-bit one-hot class and a raw zero-exponent flag, with optional denormals-are-zero (DAZ).
- A valid/ready pipeline with backpressure carries the results, and a saturating counter totals the zero results delivered.
- It sits between operand staging and min/max/compare datapaths that need class information registered.

---
 rtl/fp_class_pipe.sv | 152 +++++++++++++++
 tb/tb_fp_class_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_class_pipe.sv
// Multi-lane floating-point classifier with a valid/ready register pipeline.
// It produces a one-hot class and a raw zero-exponent flag per lane, and keeps a saturating count of delivered +/-0 lanes.
module fp_class_pipe #(
   parameter int SIGN_W      = 1,
   parameter int EXPO_W      = 8,
   parameter int MANT_W      = 23,
   parameter int LANES       = 4,
   parameter int PIPE_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      daz,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [LANES*(SIGN_W+EXPO_W+MANT_W)-1:0]   in_data,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [LANES*10-1:0]                       out_class,
   output logic [LANES-1:0]                          out_zexp,
   input  logic                                      cnt_clr,
   output logic [CNT_W-1:0]                          zero_cnt
);

   localparam int FP_W  = SIGN_W + EXPO_W + MANT_W;
   localparam int NZ_W  = $clog2(LANES + 1);
   localparam int SUM_W = ((CNT_W > NZ_W) ? CNT_W : NZ_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [9:0] classify(input logic [FP_W-1:0] fp, input logic daz_en);
      logic              sgn;
      logic [EXPO_W-1:0] ex;
      logic [MANT_W-1:0] mn;
      logic [9:0]        c;
      // With no sign field every operand is treated as positive.
      sgn = (SIGN_W > 0) ? fp[FP_W-1] : 1'b0;
      ex  = fp[MANT_W +: EXPO_W];
      mn  = fp[MANT_W-1:0];
      c   = '0;
      if (ex == '0) begin
         if (mn == '0 || daz_en) begin
            if (sgn) c[3] = 1'b1;
            else     c[4] = 1'b1;
         end else begin
            if (sgn) c[2] = 1'b1;
            else     c[5] = 1'b1;
         end
      end else if (ex == '1) begin
         if (mn == '0) begin
            if (sgn) c[0] = 1'b1;
            else     c[7] = 1'b1;
         end else if (mn[MANT_W-1]) begin
            c[9] = 1'b1;
         end else begin
            c[8] = 1'b1;
         end
      end else begin
         if (sgn) c[1] = 1'b1;
         else     c[6] = 1'b1;
      end
      return c;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [NZ_W-1:0] b);
      logic [SUM_W-1:0] s;
      s = SUM_W'(a) + SUM_W'(b);
      if (s > SUM_W'(CNT_MAX)) return CNT_MAX;
      return s[CNT_W-1:0];
   endfunction

   // ---- stage 0: combinational classification of the incoming beat
   logic [LANES*10-1:0] cls_p0;
   logic [LANES-1:0]    zexp_p0;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         cls_p0[i*10 +: 10] = classify(in_data[i*FP_W +: FP_W], daz);
         zexp_p0[i]         = (in_data[i*FP_W + MANT_W +: EXPO_W] == '0);
      end
   end

   // ---- stages 1..PIPE_STAGES: registered pipeline with collapsing bubbles
   logic [PIPE_STAGES-1:0] vld_q, vld_d, vld_src, stage_ld;
   logic [LANES*10-1:0]    cls_q    [PIPE_STAGES];
   logic [LANES*10-1:0]    cls_src  [PIPE_STAGES];
   logic [LANES-1:0]       zexp_q   [PIPE_STAGES];
   logic [LANES-1:0]       zexp_src [PIPE_STAGES];

   assign vld_src[0]  = in_valid;
   assign cls_src[0]  = cls_p0;
   assign zexp_src[0] = zexp_p0;

   for (genvar k = 1; k < PIPE_STAGES; k++) begin : g_src
      assign vld_src[k]  = vld_q[k-1];
      assign cls_src[k]  = cls_q[k-1];
      assign zexp_src[k] = zexp_q[k-1];
   end

   // A stage may load whenever any stage at or after it is empty, or the sink accepts.
   always_comb begin
      stage_ld = '0;
      vld_d    = vld_q;
      for (int k = 0; k < PIPE_STAGES; k++) begin
         stage_ld[k] = out_ready;
         for (int j = k; j < PIPE_STAGES; j++) begin
            if (!vld_q[j]) stage_ld[k] = 1'b1;
         end
         if (stage_ld[k]) vld_d[k] = vld_src[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d;
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
         if (stage_ld[k]) begin
            cls_q[k]  <= cls_src[k];
            zexp_q[k] <= zexp_src[k];
         end
      end
   end

   assign in_ready  = stage_ld[0];
   assign out_valid = vld_q[PIPE_STAGES-1];
   assign out_class = cls_q[PIPE_STAGES-1];
   assign out_zexp  = zexp_q[PIPE_STAGES-1];

   // ---- output side: count +/-0 lanes on every delivered beat
   logic [NZ_W-1:0]  nz_cnt;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      nz_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         nz_cnt = nz_cnt + NZ_W'(out_class[i*10 + 3] | out_class[i*10 + 4]);
      end
      cnt_d = cnt_q;
      if (cnt_clr)                     cnt_d = '0;
      else if (out_valid && out_ready) cnt_d = sat_add(cnt_q, nz_cnt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign zero_cnt = cnt_q;

endmodule

// File: tb/tb_fp_class_pipe.sv
// Directed bench for fp_class_pipe: FP32, four lanes, two stages, 4-bit zero counter.
module tb_fp_class_pipe;

   localparam int LANES = 4;
   localparam int S     = 2;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          daz = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [127:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [39:0]   out_class;
   logic [3:0]    out_zexp;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] zero_cnt;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fp_class_pipe #(
      .SIGN_W(1), .EXPO_W(8), .MANT_W(23), .LANES(LANES), .PIPE_STAGES(S), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .daz(daz), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_class(out_class), .out_zexp(out_zexp), .cnt_clr(cnt_clr), .zero_cnt(zero_cnt)
   );

   // Operand table with its hand-decoded class index.
   logic [31:0] tv [10] = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h807FFFFF, 32'h7F800000,
                            32'hFF800000, 32'h7F800001, 32'h7FC00000, 32'hBF800000, 32'h3F800000};
   int          tc [10] = '{4, 3, 5, 2, 7, 0, 8, 9, 1, 6};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] ocls(input int c0, input int c1, input int c2, input int c3);
      logic [9:0] one;
      one = 10'd1;
      return {one << c3, one << c2, one << c1, one << c0};
   endfunction

   function automatic logic [127:0] tbl_data(input int b);
      return {tv[(b+3)%10], tv[(b+2)%10], tv[(b+1)%10], tv[b%10]};
   endfunction

   function automatic logic [39:0] tbl_cls(input int b);
      return ocls(tc[b%10], tc[(b+1)%10], tc[(b+2)%10], tc[(b+3)%10]);
   endfunction

   function automatic logic [3:0] tbl_zexp(input int b);
      logic [3:0] z;
      for (int j = 0; j < 4; j++) z[j] = (((b + j) % 10) <= 3);
      return z;
   endfunction

   function automatic int tbl_nz(input int b);
      int n;
      n = 0;
      for (int j = 0; j < 4; j++) if (((b + j) % 10) <= 1) n++;
      return n;
   endfunction

   // One isolated beat with out_ready high: accept, then out_valid exactly two edges later.
   task automatic send_one(input logic [127:0] d, input logic dz, input logic [39:0] ec,
                           input logic [3:0] ez, input string tag);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; daz = dz;
      #1 chk({tag, "_rdy"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0; daz = 1'b0;
      chk({tag, "_lat1"}, out_valid, 0);
      @(negedge clk);
      chk({tag, "_vld"}, out_valid, 1);
      chk({tag, "_cls"}, out_class, ec);
      chk({tag, "_zexp"}, out_zexp, ez);
      @(negedge clk);
      chk({tag, "_drain"}, out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] q_cls [$];
      logic [3:0]  q_z [$];
      int          sent, rcvd, occ, exp_cnt;
      logic        acc, dlv;

      // Reset state
      #12;
      chk("rst_vld", out_valid, 0);
      chk("rst_cnt", zero_cnt, 0);
      chk("rst_rdy", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Decode sweep
      send_one({32'h807FFFFF, 32'h00000001, 32'h80000000, 32'h00000000}, 1'b0, ocls(4, 3, 5, 2), 4'hF, "decA");
      chk("decA_cnt", zero_cnt, 2);
      send_one({32'h7FC00000, 32'h7F800001, 32'hFF800000, 32'h7F800000}, 1'b0, ocls(7, 0, 8, 9), 4'h0, "decB");
      chk("decB_cnt", zero_cnt, 2);
      send_one({32'h80000000, 32'h00000000, 32'h3F800000, 32'hBF800000}, 1'b0, ocls(1, 6, 4, 3), 4'hC, "decC");
      chk("decC_cnt", zero_cnt, 4);

      // Denormals-are-zero
      send_one({32'h00000001, 32'h807FFFFF, 32'h00000001, 32'h807FFFFF}, 1'b1, ocls(3, 4, 3, 4), 4'hF, "dazD");
      chk("dazD_cnt", zero_cnt, 8);
      send_one({32'h7FC00000, 32'h7F800000, 32'h3F800000, 32'h00000000}, 1'b1, ocls(4, 6, 7, 9), 4'h1, "dazE");
      chk("dazE_cnt", zero_cnt, 9);

      @(negedge clk); cnt_clr = 1'b1;
      @(negedge clk); cnt_clr = 1'b0;
      chk("clr_idle", zero_cnt, 0);

      // Back-to-back stream: first out_valid two edges after the first accept, eight in a row
      exp_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("thr_vld", out_valid, (c >= 2 && c < 10));
         if (c >= 2 && c < 10) begin
            chk("thr_cls", out_class, tbl_cls(c - 2));
            chk("thr_zexp", out_zexp, tbl_zexp(c - 2));
            exp_cnt = exp_cnt + tbl_nz(c - 2);
            if (exp_cnt > 15) exp_cnt = 15;
         end
         if (c < 8) begin
            in_valid = 1'b1; in_data = tbl_data(c);
            #1 chk("thr_rdy", in_ready, 1);
         end else begin
            in_valid = 1'b0;
         end
      end
      chk("thr_cnt", zero_cnt, exp_cnt);

      // Random backpressure with a scoreboard
      sent = 0; rcvd = 0; occ = 0;
      for (int cyc = 0; cyc < 400 && rcvd < 20; cyc++) begin
         @(negedge clk);
         if (occ == 0) chk("bp_empty", out_valid, 0);
         if (out_valid && q_cls.size() > 0) begin
            chk("bp_cls", out_class, q_cls[0]);
            chk("bp_zexp", out_zexp, q_z[0]);
         end
         out_ready = ($urandom_range(0, 9) < 3);
         in_valid  = (sent < 20);
         in_data   = tbl_data(sent);
         #1;
         chk("bp_rdy", in_ready, !(occ == S && !out_ready));
         acc = in_valid && in_ready;
         dlv = out_valid && out_ready;
         @(posedge clk);
         if (acc) begin
            q_cls.push_back(tbl_cls(sent));
            q_z.push_back(tbl_zexp(sent));
            sent++; occ++;
         end
         if (dlv && q_cls.size() > 0) begin
            void'(q_cls.pop_front());
            void'(q_z.pop_front());
            rcvd++; occ--;
         end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp_sent", sent, 20);
      chk("bp_rcvd", rcvd, 20);
      @(negedge clk);
      @(negedge clk);
      chk("bp_idle", out_valid, 0);

      // Saturation of the 4-bit counter
      @(negedge clk); cnt_clr = 1'b1;
      @(negedge clk); cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send_one(128'h0, 1'b0, ocls(4, 4, 4, 4), 4'hF, "sat");
         chk("sat_cnt", zero_cnt, (i < 3) ? 4 * (i + 1) : 15);
      end

      // Clear coinciding with a transfer
      @(negedge clk); in_valid = 1'b1; in_data = '0;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      chk("clrx_vld", out_valid, 1);
      cnt_clr = 1'b1;
      @(negedge clk); cnt_clr = 1'b0;
      chk("clrx_cnt", zero_cnt, 0);
      chk("clrx_gone", out_valid, 0);

      // Reset with two beats in flight
      send_one(128'h0, 1'b0, ocls(4, 4, 4, 4), 4'hF, "pre");
      chk("pre_cnt", zero_cnt, 4);
      out_ready = 1'b0;
      @(negedge clk); in_valid = 1'b1; in_data = tbl_data(3);
      @(negedge clk); in_data = tbl_data(4);
      @(negedge clk); in_valid = 1'b0;
      chk("full_vld", out_valid, 1);
      chk("full_rdy", in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vld", out_valid, 0);
      chk("arst_cnt", zero_cnt, 0);
      chk("arst_rdy", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      chk("post_idle", out_valid, 0);
      send_one(tbl_data(0), 1'b0, tbl_cls(0), tbl_zexp(0), "post");
      chk("post_cnt", zero_cnt, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
